// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first two's-complement subtractor. One full-subtractor
//   cell and a borrow flip-flop work through the operands one bit per clock.
//   A new operand pair is accepted under a start/done handshake.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while busy is low
//   a       minuend, captured when start is accepted
//   b       subtrahend, captured when start is accepted
//   busy    high while the serial operation is in progress
//   done    one-cycle pulse; diff/borrow/ovf are valid from this cycle on
//   diff    (a - b) mod 2^WIDTH
//   borrow  unsigned borrow out (1 iff a < b unsigned)
//   ovf     signed overflow of a - b

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic             xBit, yBit, dBit, brNext;
  logic [WIDTH-1:0] resNext;

  assign xBit    = aSr_q[0];
  assign yBit    = bSr_q[0];
  assign dBit    = xBit ^ yBit ^ br_q;
  assign brNext  = (~xBit & yBit) | (~(xBit ^ yBit) & br_q);
  assign resNext = {dBit, res_q[WIDTH-1:1]};

  // State and datapath registers; reset clears everything, which also
  // aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aSr_q    <= '0;
      bSr_q    <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aSr_q    <= aSr_d;
      bSr_q    <= bSr_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic. DONE accepts a new start exactly like IDLE so that
  // operations can run back-to-back. On the last SHIFT cycle the cell still
  // sees the operand MSBs, so signed overflow is judged from those bits and
  // the final difference bit.
  always_comb begin
    state_d  = state_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          aSr_d   = a;
          bSr_d   = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = resNext;
        aSr_d = {1'b0, aSr_q[WIDTH-1:1]};
        bSr_d = {1'b0, bSr_q[WIDTH-1:1]};
        br_d  = brNext;
        if (cnt_q == LAST_BIT) begin
          cnt_d    = CNT_W'(WIDTH);
          state_d  = DONE;
          diff_d   = resNext;
          borrow_d = brNext;
          ovf_d    = (xBit ^ yBit) & (dBit ^ xBit);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and randomised bench for serial_subtractor (WIDTH = 8).
//   Expected results come from plain integer arithmetic on a and b.

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents an operand pair with start at the current negedge, then follows
  // the operation until done. edges counts posedges including the accepting
  // one; busyCnt counts negedge samples with busy high before done. If
  // injectAt > 0, a stray start is asserted at that edge count.
  task automatic applyStimulus(input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib,
                               input int injectAt,
                               output int edges, output int busyCnt,
                               output bit seen);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    busyCnt = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!seen && edges < 40) begin
      if (busy) busyCnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == injectAt) begin
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
  endtask

  // Compares the done-cycle outputs against integer a - b.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] ia,
                             input logic [WIDTH-1:0] ib, input int edges,
                             input int busyCnt, input bit seen);
    int ua, ub, sa, sb, sd;
    logic [WIDTH-1:0] expDiff;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    sd = sa - sb;
    expDiff = WIDTH'(ua - ub);
    checkVal({tag, ".seen"}, 32'(seen), 32'd1);
    checkVal({tag, ".edges"}, 32'(edges), 32'(WIDTH + 1));
    checkVal({tag, ".busyCycles"}, 32'(busyCnt), 32'(WIDTH));
    checkVal({tag, ".busyAtDone"}, 32'(busy), 32'd0);
    checkVal({tag, ".diff"}, 32'(diff), 32'(expDiff));
    checkVal({tag, ".borrow"}, 32'(borrow), 32'(ua < ub));
    checkVal({tag, ".ovf"}, 32'(ovf), 32'((sd > 127) || (sd < -128)));
  endtask

  initial begin
    int edges, busyCnt, gap;
    bit seen, doneSeen;
    logic [WIDTH-1:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkVal("reset.busy", 32'(busy), 32'd0);
    checkVal("reset.done", 32'(done), 32'd0);
    checkVal("reset.diff", 32'(diff), 32'd0);
    checkVal("reset.borrow", 32'(borrow), 32'd0);
    checkVal("reset.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic cases and signed-overflow corners.
    applyStimulus(8'h05, 8'h03, 0, edges, busyCnt, seen);
    checkOutput("t1_05_03", 8'h05, 8'h03, edges, busyCnt, seen);
    checkVal("t1.diffConst", 32'(diff), 32'h02);
    @(negedge clk);
    applyStimulus(8'h03, 8'h05, 0, edges, busyCnt, seen);
    checkOutput("t2_03_05", 8'h03, 8'h05, edges, busyCnt, seen);
    checkVal("t2.diffConst", 32'(diff), 32'hFE);
    @(negedge clk);
    applyStimulus(8'h00, 8'h00, 0, edges, busyCnt, seen);
    checkOutput("t2_00_00", 8'h00, 8'h00, edges, busyCnt, seen);
    @(negedge clk);
    applyStimulus(8'h80, 8'h01, 0, edges, busyCnt, seen);
    checkOutput("t3_80_01", 8'h80, 8'h01, edges, busyCnt, seen);
    checkVal("t3.ovfConst", 32'(ovf), 32'd1);
    @(negedge clk);
    applyStimulus(8'h7F, 8'hFF, 0, edges, busyCnt, seen);
    checkOutput("t3_7F_FF", 8'h7F, 8'hFF, edges, busyCnt, seen);
    checkVal("t3.diff80", 32'(diff), 32'h80);
    @(negedge clk);

    // Start while busy is ignored; results hold through IDLE.
    applyStimulus(8'h05, 8'h03, 3, edges, busyCnt, seen);
    checkOutput("t4_ignored", 8'h05, 8'h03, edges, busyCnt, seen);
    @(negedge clk);
    checkVal("t4.donePulse", 32'(done), 32'd0);
    checkVal("t4.idleBusy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("t4.holdDiff", 32'(diff), 32'h02);
    checkVal("t4.stillIdle", 32'(busy), 32'd0);

    // Back-to-back: start held at the done cycle.
    applyStimulus(8'h05, 8'h03, 0, edges, busyCnt, seen);
    checkOutput("t5_first", 8'h05, 8'h03, edges, busyCnt, seen);
    applyStimulus(8'hA0, 8'h0A, 0, edges, busyCnt, seen);
    checkOutput("t5_b2b", 8'hA0, 8'h0A, edges, busyCnt, seen);
    checkVal("t5.diffConst", 32'(diff), 32'h96);
    @(negedge clk);

    // Mid-operation reset aborts without a done pulse.
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("t6.busyBefore", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("t6.busyReset", 32'(busy), 32'd0);
    checkVal("t6.diffReset", 32'(diff), 32'd0);
    checkVal("t6.doneReset", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkVal("t6.noDone", 32'(doneSeen), 32'd0);
    applyStimulus(8'h05, 8'h03, 0, edges, busyCnt, seen);
    checkOutput("t6_after", 8'h05, 8'h03, edges, busyCnt, seen);

    // Randomised pairs, with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      applyStimulus(ra, rb, 0, edges, busyCnt, seen);
      checkOutput($sformatf("rand%0d", i), ra, rb, edges, busyCnt, seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
